// File: rtl/addsub_dispatch_ctrl.sv
// Dispatch controller for the shared add/sub ALU: round-robin pick among ready
// reservation-station entries, one op in flight, result held for the CDB slot.
module addsub_dispatch_ctrl #(
    parameter int unsigned NUM_RS   = 3,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned TAG_W    = 4,
    parameter int unsigned TAG_BASE = 1
) (
    input  logic                     clk,
    input  logic                     RST,
    input  logic [NUM_RS-1:0]        rs_ready,
    input  logic [NUM_RS-1:0]        rs_op,
    input  logic [NUM_RS*DATA_W-1:0] rs_vj,
    input  logic [NUM_RS*DATA_W-1:0] rs_vk,
    output logic [NUM_RS-1:0]        rs_issue,
    output logic                     alu_start,
    output logic [DATA_W-1:0]        alu_a,
    output logic [DATA_W-1:0]        alu_b,
    output logic                     alu_sub,
    input  logic                     alu_done,
    input  logic [DATA_W-1:0]        alu_result,
    output logic                     cdb_req,
    output logic [TAG_W-1:0]         cdb_tag,
    output logic [DATA_W-1:0]        cdb_data,
    input  logic                     cdb_grant,
    output logic                     busy
);

    localparam int unsigned IDX_W = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;

    // Every entry tag must be representable on the CDB.
    if ((TAG_BASE + NUM_RS - 1) >= (32'd1 << TAG_W)) begin : g_tag_check
        $error("addsub_dispatch_ctrl: TAG_BASE+NUM_RS-1 does not fit in TAG_W");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   scan_idx;
    logic [IDX_W-1:0]   sel;
    logic               sel_vld;
    logic               issue_ok;

    // Round-robin pick: first ready entry after the last one issued.
    always_comb begin
        sel      = '0;
        sel_vld  = 1'b0;
        scan_idx = '0;
        for (int unsigned k = 1; k <= NUM_RS; k++) begin
            scan_idx = IDX_W'((32'(rr_ptr) + k) % NUM_RS);
            if (!sel_vld && rs_ready[scan_idx]) begin
                sel     = scan_idx;
                sel_vld = 1'b1;
            end
        end
    end

    // Issue pulses are combinational so the RS can free the entry this cycle.
    always_comb begin
        issue_ok  = !RST && sel_vld && ((state == IDLE) || ((state == WB) && cdb_grant));
        alu_start = issue_ok;
        rs_issue  = issue_ok ? (NUM_RS'(1) << sel) : '0;
    end

    // Controller state, operand/result latches and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (RST) begin
            state    <= IDLE;
            rr_ptr   <= IDX_W'(NUM_RS - 1);
            alu_a    <= '0;
            alu_b    <= '0;
            alu_sub  <= 1'b0;
            cdb_req  <= 1'b0;
            cdb_tag  <= '0;
            cdb_data <= '0;
            busy     <= 1'b0;
        end else begin
            if (issue_ok) begin
                alu_a   <= rs_vj[32'(sel)*DATA_W +: DATA_W];
                alu_b   <= rs_vk[32'(sel)*DATA_W +: DATA_W];
                alu_sub <= rs_op[sel];
                cdb_tag <= TAG_W'(TAG_BASE + 32'(sel));
                rr_ptr  <= sel;
            end
            case (state)
                IDLE: begin
                    if (issue_ok) begin
                        state <= EXEC;
                        busy  <= 1'b1;
                    end
                end
                EXEC: begin
                    if (alu_done) begin
                        cdb_data <= alu_result;
                        cdb_req  <= 1'b1;
                        state    <= WB;
                    end
                end
                WB: begin
                    if (cdb_grant) begin
                        cdb_req <= 1'b0;
                        if (issue_ok) begin
                            state <= EXEC;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    cdb_req <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_addsub_dispatch_ctrl.sv
// Self-checking bench for addsub_dispatch_ctrl: directed scenarios plus a
// randomized transaction stream against a round-robin/ALU reference model.
module tb_addsub_dispatch_ctrl;

    localparam int N = 3;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   rs_ready;
    logic [N-1:0]   rs_op;
    logic [N*W-1:0] rs_vj;
    logic [N*W-1:0] rs_vk;
    logic [N-1:0]   rs_issue;
    logic           alu_start;
    logic [W-1:0]   alu_a;
    logic [W-1:0]   alu_b;
    logic           alu_sub;
    logic           alu_done;
    logic [W-1:0]   alu_result;
    logic           cdb_req;
    logic [3:0]     cdb_tag;
    logic [W-1:0]   cdb_data;
    logic           cdb_grant;
    logic           busy;

    addsub_dispatch_ctrl #(.NUM_RS(N), .DATA_W(W), .TAG_W(4), .TAG_BASE(1)) dut (
        .clk(clk), .RST(rst), .rs_ready(rs_ready), .rs_op(rs_op), .rs_vj(rs_vj),
        .rs_vk(rs_vk), .rs_issue(rs_issue), .alu_start(alu_start), .alu_a(alu_a),
        .alu_b(alu_b), .alu_sub(alu_sub), .alu_done(alu_done), .alu_result(alu_result),
        .cdb_req(cdb_req), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .cdb_grant(cdb_grant), .busy(busy)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state: last issued entry and the expected in-flight op.
    int           last;
    logic [W-1:0] exp_a, exp_b, exp_res;
    logic         exp_sub;
    logic [3:0]   exp_tag;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // First ready entry scanning last+1, last+2, ... modulo N.
    function automatic int pick(input logic [N-1:0] m, input int from);
        for (int k = 1; k <= N; k++) begin
            if (((m >> ((from + k) % N)) & 3'b001) != 3'b000) return (from + k) % N;
        end
        return -1;
    endfunction

    // Issue cycle (from IDLE, or from WB when grant=1); caller is at a negedge.
    task automatic issue(input logic [N-1:0] mask, input logic grant,
                         input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        int s;
        logic [N-1:0] oh;
        s = pick(mask, last);
        oh = N'(1 << s);
        rs_ready  = mask;
        cdb_grant = grant;
        alu_done  = 1'($urandom_range(0, 1));
        rs_vj     = {$urandom, $urandom, $urandom};
        rs_vk     = {$urandom, $urandom, $urandom};
        rs_op     = N'($urandom);
        rs_vj[s*W +: W] = a;
        rs_vk[s*W +: W] = b;
        rs_op[s]        = sub;
        #1;
        check("issue_onehot", rs_issue, oh);
        check("issue_start", alu_start, 1'b1);
        last    = s;
        exp_a   = a;
        exp_b   = b;
        exp_sub = sub;
        exp_tag = 4'(s + 1);
        exp_res = sub ? (a - b) : (a + b);
        @(negedge clk);
        cdb_grant = 1'b0;
        alu_done  = 1'b0;
        rs_ready  = mask & ~oh;
        check("exec_alu_a", alu_a, exp_a);
        check("exec_alu_b", alu_b, exp_b);
        check("exec_alu_sub", alu_sub, exp_sub);
        check("exec_busy", busy, 1'b1);
        check("exec_req", cdb_req, 1'b0);
    endtask

    // EXEC with dly cycles of no done, then done carrying the bench ALU result.
    task automatic exec(input int dly);
        for (int i = 0; i < dly; i++) begin
            rs_ready   = N'($urandom);
            cdb_grant  = 1'($urandom_range(0, 1));
            alu_done   = 1'b0;
            alu_result = $urandom;
            #1;
            check("exec_no_issue", rs_issue, '0);
            check("exec_no_start", alu_start, 1'b0);
            @(negedge clk);
            check("exec_hold_a", alu_a, exp_a);
            check("exec_hold_b", alu_b, exp_b);
            check("exec_hold_sub", alu_sub, exp_sub);
            check("exec_hold_req", cdb_req, 1'b0);
        end
        rs_ready   = N'($urandom);
        cdb_grant  = 1'($urandom_range(0, 1));
        alu_done   = 1'b1;
        alu_result = exp_res;
        #1;
        check("done_no_issue", rs_issue, '0);
        @(negedge clk);
        alu_done  = 1'b0;
        cdb_grant = 1'b0;
        check("wb_req", cdb_req, 1'b1);
        check("wb_tag", cdb_tag, exp_tag);
        check("wb_data", cdb_data, exp_res);
        check("wb_busy", busy, 1'b1);
    endtask

    // WB without grant: result held, nothing issued regardless of ready.
    task automatic wb_wait(input int dly);
        for (int i = 0; i < dly; i++) begin
            cdb_grant  = 1'b0;
            rs_ready   = N'($urandom);
            alu_done   = 1'($urandom_range(0, 1));
            alu_result = $urandom;
            #1;
            check("wb_no_issue", rs_issue, '0);
            check("wb_no_start", alu_start, 1'b0);
            @(negedge clk);
            check("wb_hold_req", cdb_req, 1'b1);
            check("wb_hold_tag", cdb_tag, exp_tag);
            check("wb_hold_data", cdb_data, exp_res);
        end
        alu_done = 1'b0;
    endtask

    // Grant with nothing ready: back to IDLE.
    task automatic release_cdb();
        cdb_grant = 1'b1;
        rs_ready  = '0;
        #1;
        check("rel_no_issue", rs_issue, '0);
        check("rel_no_start", alu_start, 1'b0);
        @(negedge clk);
        cdb_grant = 1'b0;
        check("rel_req", cdb_req, 1'b0);
        check("rel_busy", busy, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            rs_ready   = '0;
            cdb_grant  = 1'($urandom_range(0, 1));
            alu_done   = 1'($urandom_range(0, 1));
            alu_result = $urandom;
            #1;
            check("idle_no_issue", rs_issue, '0);
            @(negedge clk);
            check("idle_busy", busy, 1'b0);
            check("idle_req", cdb_req, 1'b0);
        end
        cdb_grant = 1'b0;
        alu_done  = 1'b0;
    endtask

    task automatic reset_seq();
        rst      = 1'b1;
        rs_ready = 3'b111;
        for (int i = 0; i < 2; i++) begin
            #1;
            check("rst_no_issue", rs_issue, '0);
            check("rst_no_start", alu_start, 1'b0);
            @(negedge clk);
            check("rst_busy", busy, 1'b0);
            check("rst_req", cdb_req, 1'b0);
            check("rst_alu_a", alu_a, '0);
            check("rst_alu_b", alu_b, '0);
            check("rst_alu_sub", alu_sub, 1'b0);
            check("rst_tag", cdb_tag, '0);
            check("rst_data", cdb_data, '0);
        end
        rst      = 1'b0;
        rs_ready = '0;
        last     = N - 1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit in_wb;
        rst = 1'b1; rs_ready = '0; rs_op = '0; rs_vj = '0; rs_vk = '0;
        alu_done = 1'b0; alu_result = '0; cdb_grant = 1'b0;
        @(negedge clk);
        reset_seq();

        // Single add on entry 1: 5 + 7 with tag 2, held until grant.
        issue(3'b010, 1'b0, 32'd5, 32'd7, 1'b0);
        exec(2);
        wb_wait(2);
        release_cdb();

        // Round robin with all ready, then 3'b101 after entry 2.
        issue(3'b111, 1'b0, $urandom, $urandom, 1'b0);
        exec(0);
        issue(3'b111, 1'b1, $urandom, $urandom, 1'b1);
        exec(0);
        issue(3'b111, 1'b1, $urandom, $urandom, 1'b0);
        exec(0);
        issue(3'b101, 1'b1, $urandom, $urandom, 1'b0);
        exec(0);

        // Fast path into entry 2: 9 - 4.
        issue(3'b100, 1'b1, 32'd9, 32'd4, 1'b1);
        // Stalls on done and grant.
        exec(5);
        wb_wait(3);
        release_cdb();

        // Reset mid-EXEC, then a stray done.
        idle(1);
        issue(3'b001, 1'b0, 32'd3, 32'd1, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst        = 1'b0;
        last       = N - 1;
        alu_done   = 1'b1;
        alu_result = 32'hDEAD_BEEF;
        rs_ready   = '0;
        @(negedge clk);
        alu_done = 1'b0;
        check("rst_exec_busy", busy, 1'b0);
        check("rst_exec_req", cdb_req, 1'b0);
        check("rst_exec_data", cdb_data, '0);
        idle(2);

        // Randomized transaction stream.
        in_wb = 1'b0;
        repeat (150) begin
            if (in_wb) begin
                wb_wait($urandom_range(0, 3));
                if ($urandom_range(0, 3) == 0) begin
                    release_cdb();
                    idle($urandom_range(0, 2));
                    in_wb = 1'b0;
                end
            end
            issue(N'($urandom_range(1, 7)), in_wb ? 1'b1 : 1'($urandom_range(0, 1)),
                  $urandom, $urandom, 1'($urandom_range(0, 1)));
            exec($urandom_range(0, 4));
            in_wb = 1'b1;
        end
        wb_wait(1);
        release_cdb();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
